// File: rtl/seg7_mmio_if.sv
// rtl/seg7_mmio_if.sv - CPU data-bus view of the seven-segment display register pair
interface seg7_mmio_if;
  logic [15:0] addr;
  logic [15:0] din;
  logic        we;
  logic [15:0] dout;
  logic        sel;

  modport master (output addr, output din, output we, input dout, input sel);
  modport slave  (input addr, input din, input we, output dout, output sel);
endinterface

// File: rtl/seg7_mmio.sv
// rtl/seg7_mmio.sv - memory-mapped four-digit hex display scanner (VALUE/CTRL registers)
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_mmio #(
  parameter logic [15:0] BASE_ADDR    = 16'h2002,
  parameter int          REFRESH_BITS = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  seg7_mmio_if.slave bus,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o
);
  localparam logic [15:0] CTRL_ADDR = BASE_ADDR + 16'd1;

  logic [15:0]             value_q, value_d;
  logic [15:0]             ctrl_q, ctrl_d;
  logic [REFRESH_BITS-1:0] presc_q, presc_d;
  logic [1:0]              idx_q, idx_d;
  logic                    guard_q, guard_d;
  logic [3:0]              an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic       hit_value, hit_ctrl, en, lzb, digit_blank;
  logic [3:0] nibble, blank_mask, dp_mask;

  assign hit_value  = (bus.addr == BASE_ADDR);
  assign hit_ctrl   = (bus.addr == CTRL_ADDR);
  assign bus.sel    = hit_value | hit_ctrl;
  assign bus.dout   = hit_value ? value_q : (hit_ctrl ? ctrl_q : 16'h0000);
  assign en         = ctrl_q[0];
  assign blank_mask = ctrl_q[7:4];
  assign dp_mask    = ctrl_q[11:8];

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    nibble = value_q[3:0];
    case (idx_q)
      2'd1:    nibble = value_q[7:4];
      2'd2:    nibble = value_q[11:8];
      2'd3:    nibble = value_q[15:12];
      default: nibble = value_q[3:0];
    endcase
  end

`ifdef SEG7_LZB_EN
  // Digit 0 is never suppressed so a zero value still shows a single "0".
  always_comb begin
    lzb = 1'b0;
    case (idx_q)
      2'd1:    lzb = (value_q[15:4] == 12'h000);
      2'd2:    lzb = (value_q[15:8] == 8'h00);
      2'd3:    lzb = (value_q[15:12] == 4'h0);
      default: lzb = 1'b0;
    endcase
  end
`else
  assign lzb = 1'b0;
`endif

  assign digit_blank = guard_q | ~en | blank_mask[idx_q] | lzb;

  always_comb begin
    value_d = value_q;
    ctrl_d  = ctrl_q;
    presc_d = '0;
    idx_d   = 2'd0;
    guard_d = 1'b0;
    an_d    = 4'hF;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;

    if (bus.we && hit_value) value_d = bus.din;
    if (bus.we && hit_ctrl)  ctrl_d  = bus.din;

    // Disabled scan parks at digit 0 so re-enabling starts a full first period.
    if (en) begin
      presc_d = presc_q + REFRESH_BITS'(1);
      idx_d   = idx_q;
      if (presc_q == '1) begin
        idx_d   = idx_q + 2'd1;
        guard_d = 1'b1;
      end
    end

    // The single blank guard cycle between digits avoids ghosting.
    if (!digit_blank) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hex7(nibble);
      dp_d  = ~dp_mask[idx_q];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      value_q <= 16'h0000;
      ctrl_q  <= 16'h0000;
      presc_q <= '0;
      idx_q   <= 2'd0;
      guard_q <= 1'b0;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      value_q <= value_d;
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      guard_q <= guard_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;
endmodule

// File: tb/tb_seg7_mmio.sv
// tb/tb_seg7_mmio.sv - randomized and directed check of seg7_mmio against a timeline model
module tb_seg7_mmio;
  localparam logic [15:0] BASE = 16'h2002;
  localparam int          RB   = 2;
  localparam int          P    = 1 << RB;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [3:0] an_o;
  logic [6:0] seg_o;
  logic       dp_o;

  seg7_mmio_if bus();

  seg7_mmio #(.BASE_ADDR(BASE), .REFRESH_BITS(RB)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus),
    .an_o    (an_o),
    .seg_o   (seg_o),
    .dp_o    (dp_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [6:0] hex_tbl [16];
  logic [15:0] m_value, m_ctrl;
  int          m_n;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Display as a function of how many enabled edges have elapsed since EN rose.
  function automatic logic [11:0] exp_out(input logic [15:0] v, input logic [15:0] c, input int n);
    int   idx;
    logic blank;
    logic [15:0] upper;
    idx   = (n / P) % 4;
    upper = v >> (4 * idx);
    blank = (n > 0 && n % P == 0) || !c[0] || c[4 + idx];
`ifdef SEG7_LZB_EN
    if (idx > 0 && upper == 16'h0) blank = 1'b1;
`endif
    if (blank) return {4'hF, 7'h7F, 1'b1};
    return {~(4'b0001 << idx), hex_tbl[upper[3:0]], ~c[8 + idx]};
  endfunction

  task automatic step(input logic [15:0] a, input logic [15:0] d, input logic w);
    logic [11:0] e;
    logic [15:0] ed;
    bus.addr = a;
    bus.din  = d;
    bus.we   = w;
    #1;
    ed = (a == BASE) ? m_value : ((a == BASE + 16'd1) ? m_ctrl : 16'h0);
    chk("dout", bus.dout, ed);
    chk("sel", {15'd0, bus.sel}, {15'd0, (a == BASE) || (a == BASE + 16'd1)});
    e = exp_out(m_value, m_ctrl, m_n);
    @(posedge clk_i);
    m_n = m_ctrl[0] ? m_n + 1 : 0;
    if (w && a == BASE)          m_value = d;
    if (w && a == BASE + 16'd1)  m_ctrl  = d;
    @(negedge clk_i);
    chk("an",  {12'd0, an_o},  {12'd0, e[11:8]});
    chk("seg", {9'd0, seg_o},  {9'd0, e[7:1]});
    chk("dp",  {15'd0, dp_o},  {15'd0, e[0]});
  endtask

  task automatic idle(input int cycles);
    logic [15:0] a;
    for (int i = 0; i < cycles; i++) begin
      case ($urandom_range(0, 3))
        0: a = BASE;
        1: a = BASE + 16'd1;
        2: a = BASE - 16'd1;
        default: a = 16'($urandom);
      endcase
      step(a, 16'($urandom), 1'b0);
    end
  endtask

  initial begin
    hex_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    m_value = 16'h0;
    m_ctrl  = 16'h0;
    m_n     = 0;
    bus.addr = 16'h0;
    bus.din  = 16'h0;
    bus.we   = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_an",  {12'd0, an_o}, 16'h000F);
    chk("rst_seg", {9'd0, seg_o}, 16'h007F);
    chk("rst_dp",  {15'd0, dp_o}, 16'h0001);
    reset_i = 1'b0;

    idle(50);

    step(BASE, 16'h12AF, 1'b1);
    step(BASE + 16'd1, 16'h0001, 1'b1);
    idle(24);
    step(BASE + 16'd1, 16'h0501, 1'b1);
    idle(20);
    step(BASE + 16'd1, 16'h0031, 1'b1);
    idle(20);

    // Stores to neighbouring addresses must be ignored.
    step(BASE - 16'd1, 16'hFFFF, 1'b1);
    step(BASE + 16'd2, 16'h0000, 1'b1);
    idle(8);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: step(BASE, 16'($urandom), 1'b1);
        1: step(BASE + 16'd1, 16'($urandom) | 16'($urandom_range(0, 3) != 0), 1'b1);
        2: step(16'($urandom), 16'($urandom), 1'b1);
        default: idle(1);
      endcase
    end

    step(BASE, 16'h0030, 1'b1);
    step(BASE + 16'd1, 16'h0001, 1'b1);
    idle(20);

    step(BASE, 16'h12AF, 1'b1);
    idle(10);
    step(BASE + 16'd1, 16'h0000, 1'b1);
    idle(3);
    step(BASE + 16'd1, 16'h0001, 1'b1);
    idle(20);
    step(BASE + 16'd1, 16'h0000, 1'b0);

    for (int i = 0; i < 64 && !(((m_n / P) % 4 == 3) && (m_n % P == 2)); i++) idle(1);
    chk("digit3_shown", {12'd0, an_o}, 16'h0007);
    #2;
    reset_i = 1'b1;
    #1;
    chk("async_an",  {12'd0, an_o}, 16'h000F);
    chk("async_seg", {9'd0, seg_o}, 16'h007F);
    chk("async_dp",  {15'd0, dp_o}, 16'h0001);
    m_value = 16'h0;
    m_ctrl  = 16'h0;
    m_n     = 0;
    @(negedge clk_i);
    reset_i = 1'b0;
    step(BASE, 16'h0000, 1'b0);
    step(BASE + 16'd1, 16'h0000, 1'b0);
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
